sonar_scheduler: RTL and testbench

SONAR_SCHEDULER -- requirements
Module: sonar_scheduler

---
 rtl/sonar_pkg.sv | 35 +++
 rtl/sonar_median3.sv | 39 +++
 rtl/sonar_scheduler.sv | 170 +++++++++++++++++
 tb/tb_sonar_scheduler.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// sonar_pkg - shared definitions for the three-sensor sonar scheduler.
//   State encoding (also exported on db_estado), sensor count, distance
//   width, default timing parameters and small unsigned min/max helpers.
// Optional feature macro used by the scheduler: SONAR_TIMEOUT_EN.

package sonar_pkg;

    localparam int N_SENSORS          = 3;
    localparam int DIST_W             = 12;
    localparam int TIMEOUT_CYCLES_DEF = 1500000;  // 30 ms at 50 MHz
    localparam int GUARD_CYCLES_DEF   = 500000;   // 10 ms at 50 MHz

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_STORE  = 3'd3,
        ST_GUARD  = 3'd4,
        ST_MEDIAN = 3'd5,
        ST_DONE   = 3'd6
    } state_e;

    // BCD codes order the same way as their numeric values, so plain
    // unsigned compares on the raw 12-bit code are sufficient.
    function automatic logic [DIST_W-1:0] min2(input logic [DIST_W-1:0] a,
                                               input logic [DIST_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [DIST_W-1:0] max2(input logic [DIST_W-1:0] a,
                                               input logic [DIST_W-1:0] b);
        return (a < b) ? b : a;
    endfunction

endpackage

// File: rtl/sonar_median3.sv
// sonar_median3 - combinational selection of the round result.
//   a_i/b_i/c_i   : slot values of sensors 0/1/2
//   mask_i        : bit i set = slot i holds a valid result
//   median_o      : median of 3 (all valid), smaller of 2 (two valid),
//                   the single value (one valid), 0 otherwise
//   none_valid_o  : no slot valid

module sonar_median3
    import sonar_pkg::*;
(
    input  logic [DIST_W-1:0]    a_i,
    input  logic [DIST_W-1:0]    b_i,
    input  logic [DIST_W-1:0]    c_i,
    input  logic [N_SENSORS-1:0] mask_i,
    output logic [DIST_W-1:0]    median_o,
    output logic                 none_valid_o
);

    logic [DIST_W-1:0] med3;

    // median(a,b,c) = max(min(a,b), min(max(a,b), c))
    assign med3 = max2(min2(a_i, b_i), min2(max2(a_i, b_i), c_i));

    always_comb begin
        median_o     = '0;
        none_valid_o = 1'b0;
        case (mask_i)
            3'b111:  median_o = med3;
            3'b011:  median_o = min2(a_i, b_i);
            3'b101:  median_o = min2(a_i, c_i);
            3'b110:  median_o = min2(b_i, c_i);
            3'b001:  median_o = a_i;
            3'b010:  median_o = b_i;
            3'b100:  median_o = c_i;
            default: none_valid_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/sonar_scheduler.sv
// sonar_scheduler - sequences one shared ultrasonic measurement unit over
//   three sensors and reports the median distance of each round.
// Ports:
//   clock, reset (async, active-high)
//   mensurar       : request one round (ignored outside IDLE)
//   fim_medida_in  : done pulse from the shared unit, distancia_in valid with it
//   sel            : sensor select 0..2
//   medir          : one-cycle start pulse to the shared unit
//   zera_medida    : one-cycle abort pulse (timeout build only, else 0)
//   distancia      : result of the last round
//   valid_mask     : sensors that answered in the last round
//   fim_medida     : one-cycle round-complete pulse
//   erro           : last round had no valid sensor
//   db_estado      : current state code
// Build option: define SONAR_TIMEOUT_EN to enable the per-sensor timeout.
//
// state  | meaning
// IDLE   | wait for mensurar
// START  | medir pulse for sensor sel
// WAIT   | wait for fim_medida_in (or timeout)
// STORE  | result captured, pick GUARD or MEDIAN
// GUARD  | crosstalk gap before next sensor
// MEDIAN | compute round result
// DONE   | fim_medida pulse

module sonar_scheduler
    import sonar_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int GUARD_CYCLES   = GUARD_CYCLES_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 mensurar,
    input  logic                 fim_medida_in,
    input  logic [DIST_W-1:0]    distancia_in,
    output logic [1:0]           sel,
    output logic                 medir,
    output logic                 zera_medida,
    output logic [DIST_W-1:0]    distancia,
    output logic [N_SENSORS-1:0] valid_mask,
    output logic                 fim_medida,
    output logic                 erro,
    output logic [3:0]           db_estado
);

    localparam int GW = $clog2(GUARD_CYCLES + 1);

    state_e                 state_q;
    logic [1:0]             sel_q;
    logic                   medir_q;
    logic                   fim_q;
    logic                   erro_q;
    logic [N_SENSORS-1:0]   valid_q;
    logic [DIST_W-1:0]      dist_q;
    logic [DIST_W-1:0]      slot_q [N_SENSORS];
    logic [GW-1:0]          guard_q;
    logic [DIST_W-1:0]      median;
    logic                   none_valid;

`ifdef SONAR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]          tmo_q;
    logic                   zera_q;
`endif

    sonar_median3 u_median (
        .a_i          (slot_q[0]),
        .b_i          (slot_q[1]),
        .c_i          (slot_q[2]),
        .mask_i       (valid_q),
        .median_o     (median),
        .none_valid_o (none_valid)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            medir_q <= 1'b0;
            fim_q   <= 1'b0;
            erro_q  <= 1'b0;
            valid_q <= '0;
            dist_q  <= '0;
            guard_q <= '0;
            for (int i = 0; i < N_SENSORS; i++) slot_q[i] <= '0;
`ifdef SONAR_TIMEOUT_EN
            tmo_q   <= '0;
            zera_q  <= 1'b0;
`endif
        end else begin
            medir_q <= 1'b0;
            fim_q   <= 1'b0;
`ifdef SONAR_TIMEOUT_EN
            zera_q  <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (mensurar) begin
                        sel_q   <= '0;
                        valid_q <= '0;
                        erro_q  <= 1'b0;
                        medir_q <= 1'b1;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
`ifdef SONAR_TIMEOUT_EN
                    tmo_q   <= TW'(TIMEOUT_CYCLES - 1);
`endif
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Capture on the done pulse itself: distancia_in is only
                    // guaranteed valid in that cycle. A result arriving in the
                    // expiry cycle wins over the timeout.
                    if (fim_medida_in) begin
                        slot_q[sel_q]  <= distancia_in;
                        valid_q[sel_q] <= 1'b1;
                        state_q        <= ST_STORE;
                    end
`ifdef SONAR_TIMEOUT_EN
                    else if (tmo_q == '0) begin
                        zera_q  <= 1'b1;
                        guard_q <= GW'(GUARD_CYCLES - 1);
                        state_q <= (sel_q == 2'd2) ? ST_MEDIAN : ST_GUARD;
                    end else begin
                        tmo_q <= tmo_q - TW'(1);
                    end
`endif
                end
                ST_STORE: begin
                    guard_q <= GW'(GUARD_CYCLES - 1);
                    state_q <= (sel_q == 2'd2) ? ST_MEDIAN : ST_GUARD;
                end
                ST_GUARD: begin
                    if (guard_q == '0) begin
                        sel_q   <= sel_q + 2'd1;
                        medir_q <= 1'b1;
                        state_q <= ST_START;
                    end else begin
                        guard_q <= guard_q - GW'(1);
                    end
                end
                ST_MEDIAN: begin
                    if (none_valid) erro_q <= 1'b1;
                    else            dist_q <= median;
                    fim_q   <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE:  state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign sel        = sel_q;
    assign medir      = medir_q;
    assign distancia  = dist_q;
    assign valid_mask = valid_q;
    assign fim_medida = fim_q;
    assign erro       = erro_q;
    assign db_estado  = {1'b0, state_q};
`ifdef SONAR_TIMEOUT_EN
    assign zera_medida = zera_q;
`else
    assign zera_medida = 1'b0;
`endif

endmodule

// File: tb/tb_sonar_scheduler.sv
// tb_sonar_scheduler - directed bench for sonar_scheduler with
// TIMEOUT_CYCLES=100, GUARD_CYCLES=10. Timeout scenarios are compiled in
// when SONAR_TIMEOUT_EN is defined.

module tb_sonar_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mensurar = 1'b0;
    logic        fim_medida_in = 1'b0;
    logic [11:0] distancia_in = '0;
    logic [1:0]  sel;
    logic        medir;
    logic        zera_medida;
    logic [11:0] distancia;
    logic [2:0]  valid_mask;
    logic        fim_medida;
    logic        erro;
    logic [3:0]  db_estado;

    int checks = 0;
    int errors = 0;
    int fim_cnt = 0;
    int zera_cnt = 0;
    int wait_len = 0;
    int zera_wait = 0;
    int fim_base;
    int zera_base;

    sonar_scheduler #(.TIMEOUT_CYCLES(100), .GUARD_CYCLES(10)) dut (
        .clock         (clock),
        .reset         (reset),
        .mensurar      (mensurar),
        .fim_medida_in (fim_medida_in),
        .distancia_in  (distancia_in),
        .sel           (sel),
        .medir         (medir),
        .zera_medida   (zera_medida),
        .distancia     (distancia),
        .valid_mask    (valid_mask),
        .fim_medida    (fim_medida),
        .erro          (erro),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    // Pulse counters and length of the current WAIT phase.
    always @(negedge clock) begin
        if (fim_medida)  fim_cnt  <= fim_cnt + 1;
        if (zera_medida) begin
            zera_cnt  <= zera_cnt + 1;
            zera_wait <= wait_len;
        end
        if (medir)                wait_len <= 0;
        else if (db_estado == 4'd2) wait_len <= wait_len + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_round();
        @(negedge clock);
        mensurar = 1'b1;
        @(negedge clock);
        mensurar = 1'b0;
    endtask

    // Wait for medir, check sel, then answer after 'delay' cycles of WAIT
    // (or stay silent). 'poke' pulses mensurar in the first WAIT cycle.
    task automatic respond(input logic [11:0] d, input logic [1:0] exp_sel,
                           input int delay, input bit silent, input bit poke);
        int n = 0;
        while (medir !== 1'b1 && n < 400) begin
            @(negedge clock);
            n++;
        end
        chk("medir_seen", {31'd0, medir}, 32'd1);
        chk("sel", {30'd0, sel}, {30'd0, exp_sel});
        if (silent) begin
            @(negedge clock);
        end else begin
            for (int i = 1; i <= delay; i++) begin
                @(negedge clock);
                mensurar = poke && (i == 1);
            end
            mensurar      = 1'b0;
            fim_medida_in = 1'b1;
            distancia_in  = d;
            @(negedge clock);
            fim_medida_in = 1'b0;
            distancia_in  = 12'h000;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (fim_medida !== 1'b1 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        chk("done_seen", {31'd0, fim_medida}, 32'd1);
    endtask

    task automatic finish_round(input string tag, input logic [11:0] exp_dist,
                                input logic [2:0] exp_mask, input logic exp_erro);
        wait_done();
        chk({tag, "_dist"}, {20'd0, distancia}, {20'd0, exp_dist});
        chk({tag, "_mask"}, {29'd0, valid_mask}, {29'd0, exp_mask});
        chk({tag, "_erro"}, {31'd0, erro}, {31'd0, exp_erro});
        @(negedge clock);
        chk({tag, "_idle"}, {28'd0, db_estado}, 32'd0);
        chk({tag, "_fim_cnt"}, fim_cnt - fim_base, 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk("rst_sel",   {30'd0, sel}, 32'd0);
        chk("rst_medir", {31'd0, medir}, 32'd0);
        chk("rst_zera",  {31'd0, zera_medida}, 32'd0);
        chk("rst_dist",  {20'd0, distancia}, 32'd0);
        chk("rst_mask",  {29'd0, valid_mask}, 32'd0);
        chk("rst_fim",   {31'd0, fim_medida}, 32'd0);
        chk("rst_erro",  {31'd0, erro}, 32'd0);
        chk("rst_state", {28'd0, db_estado}, 32'd0);
        reset = 1'b0;

        // Round 1: 0x045, 0x120, 0x050 -> median 0x050
        fim_base = fim_cnt;
        start_round();
        respond(12'h045, 2'd0, 5, 1'b0, 1'b0);
        respond(12'h120, 2'd1, 5, 1'b0, 1'b0);
        respond(12'h050, 2'd2, 5, 1'b0, 1'b0);
        finish_round("r1", 12'h050, 3'b111, 1'b0);
        repeat (20) @(negedge clock);
        chk("hold_dist", {20'd0, distancia}, 32'h050);
        chk("hold_mask", {29'd0, valid_mask}, 32'h7);

`ifdef SONAR_TIMEOUT_EN
        // All sensors silent: three aborts, erro set, distance kept.
        fim_base  = fim_cnt;
        zera_base = zera_cnt;
        start_round();
        respond(12'h000, 2'd0, 0, 1'b1, 1'b0);
        respond(12'h000, 2'd1, 0, 1'b1, 1'b0);
        respond(12'h000, 2'd2, 0, 1'b1, 1'b0);
        finish_round("silent", 12'h050, 3'b000, 1'b1);
        chk("silent_zera_cnt", zera_cnt - zera_base, 32'd3);
        chk("silent_zera_wait", zera_wait, 32'd100);

        // Sensor 1 silent -> smaller of 0x200 and 0x150; erro cleared at start.
        fim_base  = fim_cnt;
        zera_base = zera_cnt;
        start_round();
        chk("erro_cleared", {31'd0, erro}, 32'd0);
        respond(12'h200, 2'd0, 5, 1'b0, 1'b0);
        respond(12'h000, 2'd1, 0, 1'b1, 1'b0);
        respond(12'h150, 2'd2, 5, 1'b0, 1'b0);
        finish_round("s1_silent", 12'h150, 3'b101, 1'b0);
        chk("s1_zera_cnt", zera_cnt - zera_base, 32'd1);
        chk("s1_zera_wait", zera_wait, 32'd100);

        // Result in the very cycle the timeout expires counts as valid.
        fim_base  = fim_cnt;
        zera_base = zera_cnt;
        start_round();
        respond(12'h111, 2'd0, 100, 1'b0, 1'b0);
        respond(12'h222, 2'd1, 5, 1'b0, 1'b0);
        respond(12'h333, 2'd2, 5, 1'b0, 1'b0);
        finish_round("edge", 12'h222, 3'b111, 1'b0);
        chk("edge_zera_cnt", zera_cnt - zera_base, 32'd0);
`endif

        // Stray done pulse in IDLE is ignored.
        @(negedge clock);
        fim_medida_in = 1'b1;
        distancia_in  = 12'hFFF;
        @(negedge clock);
        fim_medida_in = 1'b0;
        distancia_in  = 12'h000;
        chk("idle_fim_ignored", {28'd0, db_estado}, 32'd0);

        // Round 2: mensurar in WAIT and GUARD, done pulse in GUARD ignored.
        fim_base = fim_cnt;
        start_round();
        respond(12'h080, 2'd0, 5, 1'b0, 1'b1);
        @(negedge clock);
        chk("in_guard", {28'd0, db_estado}, 32'd4);
        mensurar      = 1'b1;
        fim_medida_in = 1'b1;
        distancia_in  = 12'h999;
        @(negedge clock);
        mensurar      = 1'b0;
        fim_medida_in = 1'b0;
        distancia_in  = 12'h000;
        chk("guard_fim_ignored", {28'd0, db_estado}, 32'd4);
        respond(12'h300, 2'd1, 5, 1'b0, 1'b1);
        respond(12'h200, 2'd2, 5, 1'b0, 1'b0);
        finish_round("r2", 12'h200, 3'b111, 1'b0);
        repeat (30) @(negedge clock);
        chk("no_extra_round", fim_cnt - fim_base, 32'd1);
        chk("still_idle", {28'd0, db_estado}, 32'd0);

        // Round 3: asynchronous reset in WAIT of sensor 1.
        start_round();
        respond(12'h045, 2'd0, 5, 1'b0, 1'b0);
        respond(12'h000, 2'd1, 0, 1'b1, 1'b0);
        repeat (2) @(negedge clock);
        chk("pre_rst_wait", {28'd0, db_estado}, 32'd2);
        #2 reset = 1'b1;
        #1;
        chk("arst_sel",   {30'd0, sel}, 32'd0);
        chk("arst_medir", {31'd0, medir}, 32'd0);
        chk("arst_zera",  {31'd0, zera_medida}, 32'd0);
        chk("arst_dist",  {20'd0, distancia}, 32'd0);
        chk("arst_mask",  {29'd0, valid_mask}, 32'd0);
        chk("arst_fim",   {31'd0, fim_medida}, 32'd0);
        chk("arst_erro",  {31'd0, erro}, 32'd0);
        chk("arst_state", {28'd0, db_estado}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Round 4 after reset: starts at sel 0.
        fim_base = fim_cnt;
        start_round();
        respond(12'h030, 2'd0, 3, 1'b0, 1'b0);
        respond(12'h010, 2'd1, 7, 1'b0, 1'b0);
        respond(12'h020, 2'd2, 2, 1'b0, 1'b0);
        finish_round("r4", 12'h020, 3'b111, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
